// File: rtl/sram_stream_loader.sv
// Byte-stream front end for a 32-bit single-port SRAM: loads little-endian byte streams into words, dumps words as bytes.
// Optional running word checksum output is enabled with `define SRAM_LOADER_CSUM_EN.
`timescale 1ns/1ps
module sram_stream_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_byte,
    output logic                  o_in_ready,
    output logic                  o_out_valid,
    output logic [7:0]            o_out_byte,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata,
    output logic                  o_busy,
`ifdef SRAM_LOADER_CSUM_EN
    output logic [31:0]           o_checksum,
`endif
    output logic                  o_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] SEND  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic                  in_accept;
    logic                  out_accept;
    logic                  last_word;

    assign in_accept  = (state == LOAD) && i_in_valid;
    assign out_accept = (state == SEND) && i_out_ready;
    assign last_word  = (remaining == CNT_ONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            word      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr      <= i_base_addr;
                        remaining <= i_word_count;
                        byte_idx  <= '0;
                        if (i_word_count == '0)
                            state <= DONE;
                        else if (i_mode)
                            state <= FETCH;
                        else
                            state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_accept) begin
                        word[{byte_idx, 3'b000} +: 8] <= i_in_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    addr      <= addr + ADDR_ONE;
                    remaining <= remaining - CNT_ONE;
                    state     <= last_word ? DONE : LOAD;
                end
                FETCH: begin
                    word     <= i_mem_rdata;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    // Index only moves on a handshake, so the presented byte holds through stalls.
                    if (out_accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            addr      <= addr + ADDR_ONE;
                            remaining <= remaining - CNT_ONE;
                            state     <= last_word ? DONE : FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_LOADER_CSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            checksum <= '0;
        else if (state == IDLE && i_start)
            checksum <= '0;
        else if (state == WRITE)
            checksum <= checksum + word;
        else if (state == FETCH)
            checksum <= checksum + i_mem_rdata;
    end

    assign o_checksum = checksum;
`endif

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out_byte  = 8'h00;
        o_mem_addr  = '0;
        o_mem_write = 1'b0;
        o_mem_wdata = 32'h0;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        if (state != IDLE)
            o_mem_addr = addr;
        case (state)
            LOAD: o_in_ready = 1'b1;
            WRITE: begin
                o_mem_write = 1'b1;
                o_mem_wdata = word;
            end
            SEND: begin
                o_out_valid = 1'b1;
                o_out_byte  = word[{byte_idx, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed testbench for sram_stream_loader with a behavioural SRAM model and write/done monitors.
// Define SRAM_LOADER_CSUM_EN to also exercise the checksum output.
`timescale 1ns/1ps
module tb_sram_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  base = 8'h00;
    logic [8:0]  count = 9'h000;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_ready = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
`ifdef SRAM_LOADER_CSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [0:255];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_n = 0;
    int          done_n = 0;
    int          busy_n = 0;
    int          ready_seen = 0;
    logic [7:0]  wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    sram_stream_loader #(.ADDR_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_mode       (mode),
        .i_base_addr  (base),
        .i_word_count (count),
        .i_in_valid   (in_valid),
        .i_in_byte    (in_byte),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_out_byte   (out_byte),
        .i_out_ready  (out_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_write  (mem_write),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_busy       (busy),
`ifdef SRAM_LOADER_CSUM_EN
        .o_checksum   (checksum),
`endif
        .o_done       (done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Mid-cycle monitor: models the synchronous SRAM write and logs per-cycle events.
    always @(negedge clk) begin
        #1;
        if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            if (wr_n < 16) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n++;
        end
        if (done) done_n++;
        if (busy) busy_n++;
        if (in_ready) ready_seen++;
    end

    task automatic clear_log();
        wr_n = 0;
        done_n = 0;
        busy_n = 0;
        ready_seen = 0;
    endtask

    task automatic issue_cmd(input logic m, input logic [7:0] b, input logic [8:0] c);
        @(negedge clk);
        clear_log();
        start = 1'b1;
        mode = m;
        base = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_byte = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL feed_timeout in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (!done && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (waited >= 60) begin
            miscompares++;
            $display("[TB] FAIL done_timeout o_done got %b want 1", done);
        end
        @(negedge clk);
        #2;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_after_done got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_byte, mem_addr, mem_write, mem_wdata, busy, done} !== 53'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got ready=%b ov=%b ob=%h addr=%h we=%b wd=%h busy=%b done=%b want all 0",
                     in_ready, out_valid, out_byte, mem_addr, mem_write, mem_wdata, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] bytes [0:7];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        issue_cmd(1'b0, 8'h10, 9'd2);
        for (int i = 0; i < 8; i++) feed_byte(bytes[i]);
        in_valid = 1'b0;
        wait_done();
        vectors++;
        if (wr_n !== 2) begin miscompares++; $display("[TB] FAIL load_write_cycles got %0d want 2", wr_n); end
        vectors++;
        if (wr_addr[0] !== 8'h10 || wr_data[0] !== 32'h44332211) begin
            miscompares++;
            $display("[TB] FAIL load_word0 got %h@%h want 44332211@10", wr_data[0], wr_addr[0]);
        end
        vectors++;
        if (wr_addr[1] !== 8'h11 || wr_data[1] !== 32'h88776655) begin
            miscompares++;
            $display("[TB] FAIL load_word1 got %h@%h want 88776655@11", wr_data[1], wr_addr[1]);
        end
        vectors++;
        if (done_n !== 1) begin miscompares++; $display("[TB] FAIL load_done_pulses got %0d want 1", done_n); end
    endtask

    task automatic test_dump();
        logic [7:0] want [0:7];
        logic [7:0] rx [0:7];
        logic [7:0] held;
        logic       stalled;
        logic       tog;
        int         got;
        int         cyc;
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        mem[8'h10] = 32'h44332211;
        mem[8'h11] = 32'h88776655;
        issue_cmd(1'b1, 8'h10, 9'd2);
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        tog = 1'b1;
        held = 8'h00;
        while (got < 8 && cyc < 100) begin
            out_ready = tog;
            if (out_valid) begin
                if (stalled) begin
                    vectors++;
                    if (out_byte !== held) begin
                        miscompares++;
                        $display("[TB] FAIL dump_hold got %h want %h", out_byte, held);
                    end
                end
                if (tog) begin
                    rx[got] = out_byte;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_byte;
                end
            end
            tog = ~tog;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (got != 8) begin miscompares++; $display("[TB] FAIL dump_timeout bytes got %0d want 8", got); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i < got && rx[i] !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL dump_byte%0d got %h want %h", i, rx[i], want[i]);
            end
        end
        wait_done();
        vectors++;
        if (wr_n !== 0) begin miscompares++; $display("[TB] FAIL dump_no_write got %0d writes want 0", wr_n); end
        vectors++;
        if (done_n !== 1) begin miscompares++; $display("[TB] FAIL dump_done_pulses got %0d want 1", done_n); end
    endtask

    task automatic test_wrap();
        logic [7:0] bytes [0:7];
        bytes = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8};
        issue_cmd(1'b0, 8'hff, 9'd2);
        for (int i = 0; i < 8; i++) feed_byte(bytes[i]);
        in_valid = 1'b0;
        wait_done();
        vectors++;
        if (wr_n !== 2 || wr_addr[0] !== 8'hff || wr_addr[1] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL wrap_addrs got n=%0d %h,%h want n=2 ff,00", wr_n, wr_addr[0], wr_addr[1]);
        end
        vectors++;
        if (wr_data[0] !== 32'ha4a3a2a1 || wr_data[1] !== 32'ha8a7a6a5) begin
            miscompares++;
            $display("[TB] FAIL wrap_data got %h,%h want a4a3a2a1,a8a7a6a5", wr_data[0], wr_data[1]);
        end
    endtask

    task automatic test_zero_count();
        issue_cmd(1'b0, 8'h05, 9'd0);
        wait_done();
        vectors++;
        if (busy_n !== 1) begin miscompares++; $display("[TB] FAIL zero_busy_cycles got %0d want 1", busy_n); end
        vectors++;
        if (done_n !== 1) begin miscompares++; $display("[TB] FAIL zero_done_pulses got %0d want 1", done_n); end
        vectors++;
        if (wr_n !== 0) begin miscompares++; $display("[TB] FAIL zero_writes got %0d want 0", wr_n); end
        vectors++;
        if (ready_seen !== 0) begin miscompares++; $display("[TB] FAIL zero_in_ready got %0d cycles want 0", ready_seen); end
    endtask

    task automatic test_ignore_start();
        issue_cmd(1'b0, 8'h30, 9'd1);
        feed_byte(8'hb1);
        feed_byte(8'hb2);
        start = 1'b1;
        mode = 1'b1;
        base = 8'h50;
        count = 9'd3;
        feed_byte(8'hb3);
        start = 1'b0;
        feed_byte(8'hb4);
        in_valid = 1'b0;
        wait_done();
        vectors++;
        if (wr_n !== 1 || wr_addr[0] !== 8'h30 || wr_data[0] !== 32'hb4b3b2b1) begin
            miscompares++;
            $display("[TB] FAIL busy_start_ignored got n=%0d %h@%h want n=1 b4b3b2b1@30", wr_n, wr_data[0], wr_addr[0]);
        end
        vectors++;
        if (done_n !== 1) begin miscompares++; $display("[TB] FAIL busy_start_done got %0d want 1", done_n); end
    endtask

    task automatic test_reset_mid_load();
        issue_cmd(1'b0, 8'h40, 9'd1);
        feed_byte(8'hc1);
        feed_byte(8'hc2);
        feed_byte(8'hc3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_byte, mem_addr, mem_write, mem_wdata, busy, done} !== 53'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs got ready=%b addr=%h we=%b busy=%b done=%b want all 0",
                     in_ready, mem_addr, mem_write, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_n !== 0 || done_n !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort got writes=%0d done=%0d want 0,0", wr_n, done_n);
        end
        issue_cmd(1'b0, 8'h20, 9'd1);
        feed_byte(8'h01);
        feed_byte(8'h02);
        feed_byte(8'h03);
        feed_byte(8'h04);
        in_valid = 1'b0;
        wait_done();
        vectors++;
        if (wr_n !== 1 || wr_addr[0] !== 8'h20 || wr_data[0] !== 32'h04030201) begin
            miscompares++;
            $display("[TB] FAIL post_reset_load got n=%0d %h@%h want n=1 04030201@20", wr_n, wr_data[0], wr_addr[0]);
        end
    endtask

`ifdef SRAM_LOADER_CSUM_EN
    task automatic test_checksum();
        logic [7:0] bytes [0:7];
        bytes = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h02, 8'h00, 8'h00, 8'h00};
        issue_cmd(1'b0, 8'h60, 9'd2);
        for (int i = 0; i < 8; i++) feed_byte(bytes[i]);
        in_valid = 1'b0;
        wait_done();
        vectors++;
        if (checksum !== 32'h00000001) begin
            miscompares++;
            $display("[TB] FAIL checksum got %h want 00000001", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_dump();
        test_wrap();
        test_zero_count();
        test_ignore_start();
        test_reset_mid_load();
`ifdef SRAM_LOADER_CSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

endmodule
